// File: rtl/dirty_wb_ctrl.sv
// Miss/write-back sequencer: acks hits, otherwise writes back a dirty victim,
// refills the line beat by beat, updates tag/dirty state and then acks the CPU.
module dirty_wb_ctrl #(
   parameter int BEATS  = 4,
   parameter int BEAT_W = 2
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              cpu_req_i,
   input  logic              cpu_wr_i,
   input  logic              hit_i,
   input  logic              victim_dirty_i,
   input  logic              mem_ack_i,
   output logic              cpu_ack_o,
   output logic              stall_o,
   output logic              dirty_write_o,
   output logic              dirty_d_o,
   output logic              miss_o,
   output logic              tag_write_o,
   output logic              data_write_o,
   output logic              mem_rd_o,
   output logic              mem_wr_o,
   output logic [BEAT_W-1:0] beat_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WB,
      S_FILL,
      S_UPDATE,
      S_RESP
   } state_t;

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   state_t            state_q, state_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              op_wr_q, op_wr_d;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         op_wr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         op_wr_q <= op_wr_d;
      end
   end

   // Beat counter wraps to 0 on its own because BEATS is a power of 2.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      op_wr_d = op_wr_q;
      case (state_q)
         S_IDLE: begin
            if (cpu_req_i) begin
               op_wr_d = cpu_wr_i;
               if (hit_i)               state_d = S_RESP;
               else if (victim_dirty_i) state_d = S_WB;
               else                     state_d = S_FILL;
            end
         end
         S_WB: begin
            if (mem_ack_i) begin
               beat_d = beat_q + BEAT_W'(1);
               if (beat_q == LAST_BEAT) state_d = S_FILL;
            end
         end
         S_FILL: begin
            if (mem_ack_i) begin
               beat_d = beat_q + BEAT_W'(1);
               if (beat_q == LAST_BEAT) state_d = S_UPDATE;
            end
         end
         S_UPDATE: state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Everything but data_write and stall is a pure decode of registered state.
   always_comb begin
      cpu_ack_o     = (state_q == S_RESP);
      mem_wr_o      = (state_q == S_WB);
      mem_rd_o      = (state_q == S_FILL);
      tag_write_o   = (state_q == S_UPDATE);
      miss_o        = (state_q == S_UPDATE);
      dirty_write_o = (state_q == S_UPDATE) || ((state_q == S_RESP) && op_wr_q);
      dirty_d_o     = (state_q == S_RESP) && op_wr_q;
      data_write_o  = (state_q == S_FILL) && mem_ack_i;
      stall_o       = cpu_req_i && !cpu_ack_o && !reset_i;
      beat_o        = beat_q;
   end

endmodule
